dm_arbiter: RTL and testbench
=============================

// Module: dm_arbiter
// PURPOSE
//   Shares the single-port data memory (dm) between two requesters: port 0 = pipeline MEM stage,
//   port 1 = debug/DMA loader. Registered one-cycle grants, round-robin on contention, optional
//   short lock for read-modify-write. Drives dm addr/WE/WD/Byte/PC; returns dm read data.
// PARAMETERS
//   LOCK_MAX  default 4   max consecutive grants one port may hold via lock while the other requests
//   CNT_W     default 32  width of statistics counters (DM_ARB_STATS_EN only)
// PORTS
//   clk        in   1   single clock, all state on posedge
//   reset      in   1   synchronous, active-high
//   req0/req1  in   1   access request, held with payload until gnt seen
//   lock0/1    in   1   keep grant for the next access (RMW); ignored unless that port is granted
//   addr0/1    in   32  byte address
//   we0/we1    in   1   write enable
//   wd0/wd1    in   32  write data
//   byte0/1    in   1   byte access (dm Byte)
//   pc0/pc1    in   32  PC forwarded to dm for the store trace
//   gnt0/gnt1  out  1   registered grant; access completes at the end of the grant cycle
//   rdata0/1   out  32  dm read data, valid only during own gnt cycle, else 0
//   dm_addr    out  32  to dm addr        dm_we  out 1   to dm WE
//   dm_wd      out  32  to dm WD          dm_byte out 1  to dm Byte
//   dm_pc      out  32  to dm PC          dm_rdata in 32 from dm data (combinational)
// BEHAVIOUR
//   - State: IDLE, G0, G1 (one-hot of gnt0/gnt1); ptr = last port granted; lcnt = lock run counter.
//   - Reset: state IDLE, gnt0=gnt1=0, ptr=1 (port 0 wins first tie), lcnt=0, dm_we=0, rdata*=0.
//   - Next state at each edge, from req/lock sampled that edge, priority order:
//     1. granted port p has lock_p=1 and req_p=1 and (other req=0 or lcnt<LOCK_MAX-1) -> stay Gp, lcnt++
//     2. only one req -> grant it          3. both req -> grant ~ptr (round-robin)
//     4. none -> IDLE. Any transition other than rule 1 clears lcnt; every grant updates ptr.
//   - Latency: req high at edge N -> gnt high cycle N..N+1; uncontended back-to-back = 1 access/cycle.
//   - Contention: both req continuously, no lock -> strict alternation 0,1,0,1...
//   - Lock starvation cap: with other port requesting, at most LOCK_MAX consecutive grants, then switch.
//   - dm mux: in Gp, dm_addr/wd/byte/pc = port p fields; in IDLE all 0.
//   - dm_we = gnt_p & req_p & we_p & ~reset (live req gate: dropping req in grant cycle cancels write).
//   - rdata_p = gnt_p ? dm_rdata : 0 (combinational; dm read is asynchronous).
//   - Reset mid-grant: outputs return to reset values on next edge; dm_we forced 0 in reset cycle.
//   - Grant is never given to a port whose req was low at the sampling edge.
// CONFIGURATION
//   DM_ARB_STATS_EN defined: adds outputs gcnt0, gcnt1, ccnt (CNT_W each): grants per port and
//     cycles with both req high; cleared by reset, increment per cycle, wrap at 2^CNT_W.
//   Undefined: those ports and counters do not exist; arbitration identical.
// TESTING
//   1 reset, idle: all outputs 0 for 5 cycles; dm_we never 1.
//   2 req0=1 we0=1 addr0=0x10 wd0=0xA5A5A5A5 one edge -> gnt0 next cycle, dm_we=1, dm_addr=0x10; readback via port 1 = 0xA5A5A5A5.
//   3 req0=req1=1 held 6 cycles, no lock -> grants 0,1,0,1,0,1.
//   4 port0 lock0=1 with req1=1, LOCK_MAX=4 -> 4 gnt0 cycles then gnt1.
//   5 req1 dropped in gnt1 cycle with we1=1 -> dm_we=0, memory unchanged.
//   6 reset asserted during gnt0 write -> dm_we=0 that cycle, gnt0=0 next; (STATS_EN) counters 0.

Source files
------------

// File: rtl/dm_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the single-port dm.
// Port 0 is the pipeline MEM stage and port 1 is the debug/DMA loader.
interface dm_arbiter_if;
  logic        req0, req1;
  logic        lock0, lock1;
  logic [31:0] addr0, addr1;
  logic        we0, we1;
  logic [31:0] wd0, wd1;
  logic        byte0, byte1;
  logic [31:0] pc0, pc1;
  logic        gnt0, gnt1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] dm_addr;
  logic        dm_we;
  logic [31:0] dm_wd;
  logic        dm_byte;
  logic [31:0] dm_pc;
  logic [31:0] dm_rdata;

  modport slave (
    input  req0, req1, lock0, lock1, addr0, addr1, we0, we1,
           wd0, wd1, byte0, byte1, pc0, pc1, dm_rdata,
    output gnt0, gnt1, rdata0, rdata1, dm_addr, dm_we, dm_wd, dm_byte, dm_pc
  );

  modport master (
    output req0, req1, lock0, lock1, addr0, addr1, we0, we1,
           wd0, wd1, byte0, byte1, pc0, pc1, dm_rdata,
    input  gnt0, gnt1, rdata0, rdata1, dm_addr, dm_we, dm_wd, dm_byte, dm_pc
  );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter for the single-port data memory with a capped RMW lock.
// Define DM_ARB_STATS_EN to add grant/contention counters gcnt0, gcnt1, ccnt.
module dm_arbiter #(
  parameter int LOCK_MAX = 4
`ifdef DM_ARB_STATS_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic clk,
  input  logic reset,
  dm_arbiter_if.slave bus
`ifdef DM_ARB_STATS_EN
  , output logic [CNT_W-1:0] gcnt0
  , output logic [CNT_W-1:0] gcnt1
  , output logic [CNT_W-1:0] ccnt
`endif
);

  // lcnt saturates at LOCK_MAX-1, the point where a contended lock must yield
  localparam int LCNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam logic [LCNT_W-1:0] LCNT_CAP = LCNT_W'(LOCK_MAX - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic              ptr_r;
  logic [LCNT_W-1:0] lcnt_r;
  logic              gnt0_r;
  logic              gnt1_r;
  logic              hold_s;

  // Next-state selection: lock hold first, then single request, then round-robin
  always_comb begin
    hold_s      = 1'b0;
    state_nxt_s = IDLE;
    case (state_r)
      G0:      hold_s = bus.lock0 & bus.req0 & (~bus.req1 | (lcnt_r < LCNT_CAP));
      G1:      hold_s = bus.lock1 & bus.req1 & (~bus.req0 | (lcnt_r < LCNT_CAP));
      default: hold_s = 1'b0;
    endcase
    if (hold_s) begin
      state_nxt_s = state_r;
    end else if (bus.req0 & bus.req1) begin
      state_nxt_s = ptr_r ? G0 : G1;
    end else if (bus.req0) begin
      state_nxt_s = G0;
    end else if (bus.req1) begin
      state_nxt_s = G1;
    end else begin
      state_nxt_s = IDLE;
    end
  end

  // Arbitration state, registered grants, round-robin pointer and lock run counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      gnt0_r  <= 1'b0;
      gnt1_r  <= 1'b0;
      ptr_r   <= 1'b1;
      lcnt_r  <= '0;
    end else begin
      state_r <= state_nxt_s;
      gnt0_r  <= (state_nxt_s == G0);
      gnt1_r  <= (state_nxt_s == G1);
      if (hold_s) begin
        lcnt_r <= (lcnt_r != LCNT_CAP) ? lcnt_r + LCNT_W'(1) : lcnt_r;
      end else begin
        lcnt_r <= '0;
      end
      case (state_nxt_s)
        G0:      ptr_r <= 1'b0;
        G1:      ptr_r <= 1'b1;
        default: ptr_r <= ptr_r;
      endcase
    end
  end

  // Memory-side mux follows the current grant; idle drives zeros
  always_comb begin
    bus.dm_addr = 32'h0000_0000;
    bus.dm_wd   = 32'h0000_0000;
    bus.dm_byte = 1'b0;
    bus.dm_pc   = 32'h0000_0000;
    case (state_r)
      G0: begin
        bus.dm_addr = bus.addr0;
        bus.dm_wd   = bus.wd0;
        bus.dm_byte = bus.byte0;
        bus.dm_pc   = bus.pc0;
      end
      G1: begin
        bus.dm_addr = bus.addr1;
        bus.dm_wd   = bus.wd1;
        bus.dm_byte = bus.byte1;
        bus.dm_pc   = bus.pc1;
      end
      default: begin
        bus.dm_addr = 32'h0000_0000;
        bus.dm_wd   = 32'h0000_0000;
        bus.dm_byte = 1'b0;
        bus.dm_pc   = 32'h0000_0000;
      end
    endcase
  end

  assign bus.gnt0 = gnt0_r;
  assign bus.gnt1 = gnt1_r;

  // A requester dropping req inside its grant cycle cancels the write
  assign bus.dm_we = ~reset & ((gnt0_r & bus.req0 & bus.we0) | (gnt1_r & bus.req1 & bus.we1));

  assign bus.rdata0 = gnt0_r ? bus.dm_rdata : 32'h0000_0000;
  assign bus.rdata1 = gnt1_r ? bus.dm_rdata : 32'h0000_0000;

`ifdef DM_ARB_STATS_EN
  // Statistics: grant cycles per port and cycles with both ports requesting
  always_ff @(posedge clk) begin
    if (reset) begin
      gcnt0 <= '0;
      gcnt1 <= '0;
      ccnt  <= '0;
    end else begin
      gcnt0 <= gnt0_r ? gcnt0 + CNT_W'(1) : gcnt0;
      gcnt1 <= gnt1_r ? gcnt1 + CNT_W'(1) : gcnt1;
      ccnt  <= (bus.req0 & bus.req1) ? ccnt + CNT_W'(1) : ccnt;
    end
  end
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a small word-addressed memory model on the dm side.
module tb_dm_arbiter;
  logic clk;
  logic reset;
  int   n_run;
  int   n_fail;

  dm_arbiter_if bus ();

`ifdef DM_ARB_STATS_EN
  logic [31:0] gcnt0, gcnt1, ccnt;
  dm_arbiter #(.LOCK_MAX(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .gcnt0(gcnt0), .gcnt1(gcnt1), .ccnt(ccnt)
  );
`else
  dm_arbiter #(.LOCK_MAX(4)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
`endif

  logic [31:0] mem [0:63];
  assign bus.dm_rdata = mem[bus.dm_addr[7:2]];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
    end else if (bus.dm_we) begin
      mem[bus.dm_addr[7:2]] <= bus.dm_wd;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0 = 1'b0;  bus.req1 = 1'b0;
    bus.lock0 = 1'b0; bus.lock1 = 1'b0;
    bus.addr0 = 32'h0; bus.addr1 = 32'h0;
    bus.we0 = 1'b0;   bus.we1 = 1'b0;
    bus.wd0 = 32'h0;  bus.wd1 = 32'h0;
    bus.byte0 = 1'b0; bus.byte1 = 1'b0;
    bus.pc0 = 32'h0;  bus.pc1 = 32'h0;
  endtask

  initial begin
    logic [1:0] exp_g;
    n_run  = 0;
    n_fail = 0;
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    check("rst_gnt", {30'h0, bus.gnt1, bus.gnt0}, 32'h0);
    check("rst_we", {31'h0, bus.dm_we}, 32'h0);
    reset = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_gnt", {30'h0, bus.gnt1, bus.gnt0}, 32'h0);
      check("idle_we", {31'h0, bus.dm_we}, 32'h0);
      check("idle_addr", bus.dm_addr, 32'h0);
      check("idle_rd", bus.rdata0 | bus.rdata1, 32'h0);
    end

    // 2: port 0 write, then port 1 readback
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'h10;
    bus.wd0 = 32'hA5A5_A5A5; bus.pc0 = 32'h0000_0400;
    tick();
    check("w_gnt", {30'h0, bus.gnt1, bus.gnt0}, 32'h1);
    check("w_we", {31'h0, bus.dm_we}, 32'h1);
    check("w_addr", bus.dm_addr, 32'h10);
    check("w_wd", bus.dm_wd, 32'hA5A5_A5A5);
    check("w_pc", bus.dm_pc, 32'h0000_0400);
    tick();
    bus.req0 = 1'b0; bus.we0 = 1'b0;
    #1;
    check("w_regnt", {30'h0, bus.gnt1, bus.gnt0}, 32'h1);
    check("w_cancel", {31'h0, bus.dm_we}, 32'h0);
    tick();
    check("w_idle", {30'h0, bus.gnt1, bus.gnt0}, 32'h0);
    bus.req1 = 1'b1; bus.addr1 = 32'h10; bus.byte1 = 1'b1;
    tick();
    check("r_gnt", {30'h0, bus.gnt1, bus.gnt0}, 32'h2);
    check("r_data1", bus.rdata1, 32'hA5A5_A5A5);
    check("r_data0", bus.rdata0, 32'h0);
    check("r_byte", {31'h0, bus.dm_byte}, 32'h1);
    check("r_we", {31'h0, bus.dm_we}, 32'h0);
    idle_inputs();
    tick();

    // 3: contention without lock alternates starting with port 0
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      check("rr_gnt", {30'h0, bus.gnt1, bus.gnt0}, {30'h0, exp_g});
    end
    idle_inputs();
    tick();
    check("rr_idle", {30'h0, bus.gnt1, bus.gnt0}, 32'h0);

    // 4: locked port 0 yields after LOCK_MAX grants
    bus.req0 = 1'b1; bus.req1 = 1'b1; bus.lock0 = 1'b1;
    bus.addr0 = 32'h20; bus.addr1 = 32'h30;
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_g = (i < 4) ? 2'b01 : 2'b10;
      check("lk_gnt", {30'h0, bus.gnt1, bus.gnt0}, {30'h0, exp_g});
      check("lk_addr", bus.dm_addr, (i < 4) ? 32'h20 : 32'h30);
    end
    idle_inputs();
    tick();

    // 5: port 1 drops req inside its write grant
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 32'h10; bus.wd1 = 32'h1234_5678;
    tick();
    check("dr_gnt", {30'h0, bus.gnt1, bus.gnt0}, 32'h2);
    check("dr_we_on", {31'h0, bus.dm_we}, 32'h1);
    bus.req1 = 1'b0;
    #1;
    check("dr_we_off", {31'h0, bus.dm_we}, 32'h0);
    tick();
    bus.we1 = 1'b0;
    bus.req0 = 1'b1; bus.addr0 = 32'h10;
    tick();
    check("dr_mem", bus.rdata0, 32'hA5A5_A5A5);
    idle_inputs();
    tick();

    // 6: reset during a port 0 write
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'h14; bus.wd0 = 32'hDEAD_BEEF;
    tick();
    check("rw_gnt", {30'h0, bus.gnt1, bus.gnt0}, 32'h1);
    reset = 1'b1;
    #1;
    check("rw_we", {31'h0, bus.dm_we}, 32'h0);
    tick();
    check("rw_gnt_off", {30'h0, bus.gnt1, bus.gnt0}, 32'h0);
    check("rw_addr", bus.dm_addr, 32'h0);
`ifdef DM_ARB_STATS_EN
    check("rw_gcnt0", gcnt0, 32'h0);
    check("rw_gcnt1", gcnt1, 32'h0);
    check("rw_ccnt", ccnt, 32'h0);
`endif
    reset = 1'b0;
    idle_inputs();
    tick();
    check("end_idle", {30'h0, bus.gnt1, bus.gnt0}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
